// File: rtl/timer_if.sv
// timer_if: peripheral-bus signals between the CPU bus fabric and the timer.
// The bus side drives address/strobe/data; the timer returns read data and
// its interrupt request.
interface timer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        irq;

    modport master (
        output addr,
        output we,
        output write_data,
        input  read_data,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  write_data,
        output read_data,
        output irq
    );
endinterface

// File: rtl/timer.sv
// timer: memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a
// registered interrupt request (irq = flag & IM).
// Optional feature macro: TIMER_AUTO_RELOAD_EN. When defined, CTRL.MODE=1
// reloads COUNT from PRESET after every terminal count; when undefined, MODE
// reads 0, ignores writes and every terminal count behaves as one-shot.
module timer (
    input  logic   clk,
    input  logic   reset,
    timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;
    logic        tc_set;
    logic        reload_en;
    logic [1:0]  mode_q;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [31:0] rdata;
    logic        unused_wdata;

    assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
    assign preset_wr = bus.we && (bus.addr == 2'd1);

`ifdef TIMER_AUTO_RELOAD_EN
    logic [1:0] mode_d;

    // MODE field: stored exactly as written, only MODE=1 selects reload
    always_comb begin
        mode_d = mode_q;
        if (ctrl_wr) begin
            mode_d = bus.write_data[2:1];
        end
    end

    // MODE register
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 2'd0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign reload_en    = (mode_q == 2'd1);
    assign unused_wdata = ^bus.write_data[31:4];
`else
    // Without auto-reload the MODE field does not exist and reads as zero
    assign mode_q       = 2'd0;
    assign reload_en    = 1'b0;
    assign unused_wdata = ^{bus.write_data[31:4], bus.write_data[2:1]};
`endif

    // Next-state logic: countdown FSM first, then bus writes layered on top
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        tc_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = INT;
                    flag_d  = 1'b1;
                    tc_set  = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INT: begin
                if (reload_en) begin
                    flag_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A CTRL write overrides the FSM's own EN update. A terminal count on
        // the same edge still raises the flag so the interrupt is not lost.
        if (ctrl_wr) begin
            en_d = bus.write_data[0];
            im_d = bus.write_data[3];
            if (!tc_set) begin
                flag_d = 1'b0;
            end
        end

        if (preset_wr) begin
            preset_d = bus.write_data;
        end

        irq_d = flag_d & im_d;
    end

    // State and register file update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational register read
    always_comb begin
        rdata = 32'd0;
        case (bus.addr)
            2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
            2'd1:    rdata = preset_q;
            2'd2:    rdata = count_q;
            default: rdata = 32'd0;
        endcase
    end

    assign bus.read_data = rdata;
    assign bus.irq       = irq_q;
endmodule
